// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : multi-cycle decode/issue/writeback control for the RV32I ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  input  logic [WIDTH-1:0]   rs1_data,
  input  logic [WIDTH-1:0]   rs2_data,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [OPWIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               rd_we,
  output logic [4:0]         rd_addr,
  output logic [WIDTH-1:0]   rd_wdata,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_EXE  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;

  state_t               state_q, state_d;
  logic [31:0]          ir_q, ir_d;
  logic [WIDTH-1:0]     alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0]     alu_in2_q, alu_in2_d;
  logic [OPWIDTH-1:0]   alu_op_q, alu_op_d;
  logic                 rd_we_q, rd_we_d;
  logic [4:0]           rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]     rd_wdata_q, rd_wdata_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;

  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic                 w_legal;
  logic [WIDTH-1:0]     w_in1;
  logic [WIDTH-1:0]     w_in2;
  logic [OPWIDTH-1:0]   w_op;

  assign w_opcode = ir_q[6:0];
  assign w_funct3 = ir_q[14:12];
  assign w_funct7 = ir_q[31:25];

  // Operand/op selection and legality, evaluated from the latched instruction
  always_comb begin
    w_legal = 1'b0;
    w_in1   = rs1_data;
    w_in2   = rs2_data;
    w_op    = OPWIDTH'({ir_q[30], w_funct3, ir_q[5]});
    unique case (w_opcode)
      C_OPC_OP: begin
        w_legal = (w_funct7 == 7'b0000000) ||
                  ((w_funct7 == 7'b0100000) &&
                   ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      C_OPC_OP_IMM: begin
        w_in2 = WIDTH'($signed(ir_q[31:20]));
        if (w_funct3 == 3'b001) begin
          w_legal = (w_funct7 == 7'b0000000);
        end else if (w_funct3 == 3'b101) begin
          w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
        end else begin
          w_legal = 1'b1;
        end
      end
      C_OPC_LUI: begin
        w_legal = 1'b1;
        w_in1   = '0;
        w_in2   = WIDTH'($signed({ir_q[31:12], 12'b0}));
        w_op    = '0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Pulses default low so WB clears them on its way back to IDLE
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    alu_op_d   = alu_op_q;
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    rd_we_d    = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        alu_in1_d = w_in1;
        alu_in2_d = w_in2;
        alu_op_d  = w_op;
        if (w_legal) begin
          state_d = S_EXE;
        end else begin
          state_d   = S_WB;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end
      end
      S_EXE: begin
        rd_wdata_d = alu_out;
        rd_addr_d  = ir_q[11:7];
        rd_we_d    = |ir_q[11:7];
        done_d     = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      alu_op_q   <= '0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      alu_op_q   <= alu_op_d;
      rd_we_q    <= rd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  // Held low while reset is asserted so nothing is offered mid-abort
  assign instr_ready = rst_n & (state_q == S_IDLE);
  assign rs1_addr    = ir_q[19:15];
  assign rs2_addr    = ir_q[24:20];
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_op      = alu_op_q;
  assign rd_we       = rd_we_q;
  assign rd_addr     = rd_addr_q;
  assign rd_wdata    = rd_wdata_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl : directed bench with an instruction-level reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        done;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  alu_issue_ctrl #(.WIDTH(32), .OPWIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Register-file stub: fixed contents
  logic [31:0] rf [32];
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0100_0000 + i;
    rf[0] = 32'd0;
    rf[1] = 32'd10;
    rf[2] = 32'd3;
    rf[4] = 32'h8000_0000;
  end
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  // ALU stub driven purely by the op code the controller presents
  function automatic logic [31:0] alu_stub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op);
    logic [2:0] sel;
    sel = op[3:1];
    case (sel)
      3'd0: alu_stub = (op[4] && op[0]) ? a - b : a + b;
      3'd1: alu_stub = a << b[4:0];
      3'd2: alu_stub = {31'd0, $signed(a) < $signed(b)};
      3'd3: alu_stub = {31'd0, a < b};
      3'd4: alu_stub = a ^ b;
      3'd5: alu_stub = op[4] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: alu_stub = a | b;
      default: alu_stub = a & b;
    endcase
  endfunction
  assign alu_out = alu_stub(alu_in1, alu_in2, alu_op);

  // Instruction-level reference: what an instruction must do architecturally
  typedef struct {
    logic        legal;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  op;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] a, b;
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    a = rf[e.rs1];
    b = rf[e.rs2];
    e.legal = 1'b0;
    e.op = {ins[30], f3, ins[5]};
    if (ins[6:0] == 7'h33) begin
      e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (ins[6:0] == 7'h13) begin
      b = {{20{ins[31]}}, ins[31:20]};
      e.legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    end else if (ins[6:0] == 7'h37) begin
      a = 32'd0;
      b = {ins[31:12], 12'd0};
      e.legal = 1'b1;
      e.op = 5'd0;
    end
    e.in1 = a;
    e.in2 = b;
    case (f3)
      3'd0: e.res = (ins[6:0] == 7'h33 && f7 == 7'h20) ? a - b : a + b;
      3'd1: e.res = a << b[4:0];
      3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
      3'd4: e.res = a ^ b;
      3'd5: e.res = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: e.res = a | b;
      default: e.res = a & b;
    endcase
    if (ins[6:0] == 7'h37) e.res = b;
    return e;
  endfunction

  // Model timeline: cycles since acceptance (0 = idle)
  int   cnt = 0;
  int   acc_count = 0;
  exp_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
    end else if (cnt == 0) begin
      if (instr_valid) begin
        cnt       <= 1;
        m         <= model(instr);
        acc_count <= acc_count + 1;
      end
    end else if (cnt == (m.legal ? 3 : 2)) begin
      cnt <= 0;
    end else begin
      cnt <= cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [31:0] last_wdata, last_in1, last_in2;
  logic [4:0]  last_addr, last_op;
  logic        last_we, last_illegal;
  int          we_pulses = 0;
  time         dacc[$];

  always @(negedge clk) begin
    logic e_done;
    if (!rst_n) begin
      chk("rst_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_we", {31'd0, rd_we}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_wdata", rd_wdata, 32'd0);
      chk("rst_in1", alu_in1, 32'd0);
      chk("rst_in2", alu_in2, 32'd0);
    end else begin
      e_done = (cnt != 0) && (cnt == (m.legal ? 3 : 2));
      chk("ready", {31'd0, instr_ready}, {31'd0, cnt == 0});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("illegal", {31'd0, illegal}, {31'd0, e_done && !m.legal});
      chk("rd_we", {31'd0, rd_we}, {31'd0, e_done && m.legal && m.rd != 5'd0});
      if (cnt == 1) begin
        chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, m.rs1});
        chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, m.rs2});
      end
      if (cnt >= 2 && m.legal) begin
        chk("alu_in1", alu_in1, m.in1);
        chk("alu_in2", alu_in2, m.in2);
        chk("alu_op", {27'd0, alu_op}, {27'd0, m.op});
        last_in1 = alu_in1;
        last_in2 = alu_in2;
        last_op  = alu_op;
      end
      if (e_done && m.legal) begin
        chk("rd_addr", {27'd0, rd_addr}, {27'd0, m.rd});
        chk("rd_wdata", rd_wdata, m.res);
      end
      if (done) begin
        last_wdata   = rd_wdata;
        last_addr    = rd_addr;
        last_we      = rd_we;
        last_illegal = illegal;
      end
      if (rd_we) we_pulses++;
      if (instr_ready && instr_valid) dacc.push_back($time);
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, expected completion (t=%0t)", name, $time);
  endtask

  task automatic wait_accept(input int start);
    bit ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wait_cycle();
      if (acc_count != start) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("accept");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wait_cycle();
      if (cnt == 0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("idle");
  endtask

  task automatic issue(input logic [31:0] ins, input bit garbage);
    instr       = ins;
    instr_valid = 1'b1;
    wait_accept(acc_count);
    if (garbage) begin
      instr = 32'hFFFF_FFFF;
      wait_cycle();
    end
    instr_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wp;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);
    chk("wdata_after_reset", rd_wdata, 32'd0);
    wait_cycle();

    issue(32'h0050_0093, 1'b1);                       // ADDI x1,x0,5
    chk("addi_wdata", last_wdata, 32'd5);
    chk("addi_addr", {27'd0, last_addr}, 32'd1);
    chk("addi_we", {31'd0, last_we}, 32'd1);
    chk("addi_in2", last_in2, 32'd5);

    issue(32'h4020_81B3, 1'b0);                       // SUB x3,x1,x2
    chk("sub_wdata", last_wdata, 32'd7);
    chk("sub_op", {27'd0, last_op}, 32'b10001);

    issue(32'h4042_5293, 1'b0);                       // SRAI x5,x4,4
    chk("srai_wdata", last_wdata, 32'hF800_0000);
    chk("srai_op", {27'd0, last_op}, 32'b11010);
    chk("srai_shamt", {27'd0, last_in2[4:0]}, 32'd4);

    issue(32'h1234_53B7, 1'b0);                       // LUI x7,0x12345
    chk("lui_in1", last_in1, 32'd0);
    chk("lui_in2", last_in2, 32'h1234_5000);
    chk("lui_op", {27'd0, last_op}, 32'd0);

    issue(32'h0020_C233, 1'b0);                       // XOR x4,x1,x2
    chk("xor_wdata", last_wdata, 32'd9);

    issue(32'hFFF0_8313, 1'b0);                       // ADDI x6,x1,-1
    chk("addi_neg_wdata", last_wdata, 32'd9);

    issue(32'h0010_0013, 1'b0);                       // ADDI x0,x0,1
    chk("x0_we", {31'd0, last_we}, 32'd0);

    issue(32'h0000_A003, 1'b1);                       // LW: illegal
    chk("lw_illegal", {31'd0, last_illegal}, 32'd1);
    issue(32'h4020_9093, 1'b0);                       // SLLI funct7=0100000
    chk("slli_illegal", {31'd0, last_illegal}, 32'd1);
    issue(32'h4020_9233, 1'b0);                       // SLL funct7=0100000
    chk("sll_illegal", {31'd0, last_illegal}, 32'd1);
    issue(32'h0050_0090, 1'b0);                       // ADDI with ir[1:0]=00
    chk("lowbits_illegal", {31'd0, last_illegal}, 32'd1);

    // Back-to-back with instr_valid held high
    instr       = 32'h0030_0113;
    instr_valid = 1'b1;
    wait_accept(acc_count);
    instr = 32'h0070_0193;
    wait_accept(acc_count);
    instr_valid = 1'b0;
    wait_idle();
    chk("b2b_wdata", last_wdata, 32'd7);
    if (dacc.size() >= 2)
      chk("b2b_spacing", 32'(dacc[dacc.size()-1] - dacc[dacc.size()-2]), 32'd40);
    else
      timeout("b2b_accepts");

    // Reset while the instruction is in EXE
    wp          = we_pulses;
    instr       = 32'h0050_0093;
    instr_valid = 1'b1;
    wait_accept(acc_count);
    instr_valid = 1'b0;
    wait_cycle();
    rst_n = 1'b0;
    wait_cycle();
    wait_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_no_we", 32'(we_pulses - wp), 32'd0);
    wait_cycle();

    issue(32'h0020_C233, 1'b0);                       // XOR after abort
    chk("post_reset_wdata", last_wdata, 32'd9);

    repeat (2) wait_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
